// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit and its UART transmit serializer:
// FSM state encoding, word/byte derivation and parameter sanity helpers.
package debug_pkg;

    // Serializer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_e;

    // Number of UART bytes in one debug word
    function automatic int bytes_per_word(input int nbits, input int data_bits);
        return nbits / data_bits;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Word must split evenly into bytes; FIFO depth must be a power of two >= 2
    function automatic bit params_ok(input int nbits, input int data_bits, input int depth);
        return (data_bits > 0) && (nbits >= data_bits) && ((nbits % data_bits) == 0)
               && is_pow2(depth) && (depth >= 2);
    endfunction

endpackage

// File: rtl/debug_tx_serializer_sync_fifo.sv
// Small synchronous word FIFO with occupancy count. The head word is visible
// combinationally so the consumer can pop and capture it in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow so the count can never wrap
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers and count; pointers wrap naturally as DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage write; contents need no reset since the count gates reads
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and count registers; clear flushes everything
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/debug_tx_serializer.sv
// Buffers debug words in a FIFO and feeds them to the UART transmitter one
// byte at a time using the start/done handshake.
module debug_tx_serializer
    import debug_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clear,
    input  logic                          i_word_valid,
    input  logic [NBITS-1:0]              i_word,
    output logic                          o_word_ready,
    output logic [DATA_BITS-1:0]          o_uart_tx_data,
    output logic                          o_uart_tx_start,
    input  logic                          i_uart_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_busy
);

    localparam int BYTES = bytes_per_word(NBITS, DATA_BITS);
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    generate
        if (!params_ok(NBITS, DATA_BITS, FIFO_DEPTH)) begin : g_bad_params
            $error("debug_tx_serializer: NBITS must be a multiple of DATA_BITS and FIFO_DEPTH a power of two >= 2");
        end
    endgenerate

    tx_state_e               state_q, state_d;
    logic [NBITS-1:0]        shift_q, shift_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NBITS-1:0]        shift_adv;
    logic [NBITS-1:0]        fifo_head;
    logic                    fifo_pop, fifo_push, fifo_full, fifo_empty;

    assign fifo_push = i_word_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (NBITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .clear_i (i_clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (i_word),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (o_fifo_count)
    );

    // Byte order is fixed at elaboration: the outgoing byte always sits at the
    // end of the shift register that is shifted away after each done.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_adv      = shift_q << DATA_BITS;
            assign o_uart_tx_data = shift_q[NBITS-1 -: DATA_BITS];
        end else begin : g_lsb_first
            assign shift_adv      = shift_q >> DATA_BITS;
            assign o_uart_tx_data = shift_q[DATA_BITS-1:0];
        end
    endgenerate

    assign o_word_ready    = !fifo_full;
    assign o_uart_tx_start = (state_q == ST_START);
    assign o_busy          = (state_q != ST_IDLE) || !fifo_empty;

    // Next-state logic: load words, advance bytes, chain words without idling
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    idx_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_uart_tx_done) begin
                    if (idx_q != LAST_IDX) begin
                        shift_d = shift_adv;
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_START;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        idx_d    = '0;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; clear abandons any byte in flight
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else if (i_clear) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: doc/debug_tx_serializer.md
Name: debug_tx_serializer

Overview:
- Sits between the debug unit and the UART transmitter.
- Accepts NBITS-wide words (PC, register-file values, data-memory values, cycle count) over a valid/ready handshake and buffers them in a small FIFO.
- Splits each word into DATA_BITS-wide bytes and drives the UART TX start/done handshake one byte at a time.
- Lets the debug unit queue whole words without tracking byte-level UART timing.

Parameters:
- NBITS, 32, word width; must be a multiple of DATA_BITS.
- DATA_BITS, 8, UART byte width.
- FIFO_DEPTH, 4, word FIFO depth; must be a power of two and at least 2.
- MSB_FIRST, 0, byte order: 0 sends byte 0 (bits DATA_BITS-1:0) first; 1 sends the top byte first.

Ports:
- i_clk  in  1  system clock (clk_wz domain).
- i_reset  in  1  asynchronous, active-low reset.
- i_clear  in  1  synchronous flush of the FIFO and the FSM.
- i_word_valid  in  1  producer has a word.
- i_word  in  NBITS  word to send.
- o_word_ready  out  1  FIFO not full; a word is accepted when valid and ready are both 1.
- o_uart_tx_data  out  DATA_BITS  byte to the UART.
- o_uart_tx_start  out  1  one-cycle start pulse to the UART.
- i_uart_tx_done  in  1  UART byte-complete pulse.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO.
- o_busy  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - FIFO empty, pointers and count 0.
  - FSM in IDLE, shift register 0, byte index 0.
  - Outputs: o_uart_tx_start=0, o_uart_tx_data=0, o_word_ready=1, o_busy=0.
- i_clear=1 has the same effect synchronously and overrides every other event in that cycle. A byte already in flight at the UART is abandoned; its later done pulse is ignored.
- Constants: BYTES = NBITS/DATA_BITS; LAST = BYTES-1.
- FIFO:
  - Push on valid&&ready; pop only from the FSM.
  - Push and pop in the same cycle: count unchanged. When full, pop-plus-push is not possible because ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_word_ready = (count != FIFO_DEPTH), combinational from count.
- FSM states:
  - IDLE: if count>0, pop the head word into the shift register, set byte index 0, go to START.
  - START: o_uart_tx_start=1 for exactly this cycle; go to WAIT.
  - WAIT: hold. On i_uart_tx_done:
    - If index<LAST: shift by DATA_BITS (right if MSB_FIRST=0, left otherwise), increment index, go to START.
    - If index==LAST and count>0: pop the next word, index=0, go to START. Words go back-to-back with no IDLE cycle.
    - If index==LAST and count==0: go to IDLE.
- i_uart_tx_done outside WAIT is ignored.
- o_uart_tx_data:
  - Registered; equals the low byte (or high byte when MSB_FIRST=1) of the shift register.
  - Valid in the START cycle and held stable through WAIT until the next shift.
- Latency:
  - Word accepted at edge E0 into an empty, idle block: pop at E1, o_uart_tx_start high in the cycle after E1.
  - Between bytes: done sampled at edge Ed, start high in the cycle after Ed, then WAIT. Start is never high two cycles in a row.
- o_fifo_count and o_busy are registered/derived from state and update the cycle after the event.
- Per-word throughput: BYTES × (UART byte time + 2 cycles).

Decomposition:
- Shared package/header (debug_pkg), used by the debug unit as well:
  - FSM state encoding constants: IDLE, START, WAIT.
  - BYTES derivation.
  - Static checks that NBITS % DATA_BITS == 0 and that FIFO_DEPTH is a power of two.
- One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated with width NBITS.
- The FSM and shift register stay in debug_tx_serializer.

Test Plan:
- Reset and idle:
  - Stimulus: hold i_reset=0 mid-transfer, release, then no valid.
  - Response: all outputs at reset values; o_word_ready=1; no start pulse for 100 cycles.
- Single word, LSB first:
  - Stimulus: push 0xDEADBEEF; UART model returns done 10 cycles after each start.
  - Response: bytes EF, BE, AD, DE, four start pulses, first start in the second cycle after acceptance; o_busy falls after the last done.
- MSB_FIRST=1:
  - Stimulus: push 0x12345678.
  - Response: bytes 12, 34, 56, 78.
- FIFO full and back-to-back:
  - Stimulus: push 5 words 0x0000000N (N=1..5) on consecutive cycles with slow done.
  - Response: o_word_ready=0 once 4 words are held; the 5th word is held by the producer and accepted after the first pop. 20 bytes emitted in order; no IDLE cycle between words.
- Spurious done and clear:
  - Stimulus: done pulse in IDLE, then i_clear during WAIT of byte 2 of 0xAABBCCDD with 2 words queued.
  - Response: spurious done causes no state change. After clear: count=0, FSM IDLE, no further start pulses, and the late done is ignored.
- Simultaneous push and pop:
  - Stimulus: push on the exact cycle the FSM pops from count=2.
  - Response: count stays 2 and the order is preserved.
